wave_capture_buffer: RTL and testbench

Triggered sample capture buffer directly upstream of the waveform display stage. Accepts 8-bit ADC samples, waits for a level/slope trigger, stores one screen's worth of decimated samples into the back bank of a ping-pong RAM, and swaps banks at frame start so the display never tears. During scan-out it returns the stored sample for the current `pixel_xpos` as the display's 8-bit `datain`.

---
 rtl/wave_capture_buffer_if.sv | 30 +++
 rtl/wave_capture_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_wave_capture_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_buffer_if.sv
// wave_capture_buffer_if: sample input, trigger controls, scan position and
// display-side outputs of the wave capture buffer, bundled as one port.
interface wave_capture_buffer_if;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        run;
  logic [7:0]  trig_level;
  logic        trig_slope;
  logic [7:0]  decim;
  logic [11:0] pixel_xpos;
  logic [11:0] pixel_ypos;
  logic [7:0]  wave_data;
  logic        capture_busy;
  logic        frame_swap;
  logic [1:0]  trig_state;

  // Side that supplies samples and scan position and consumes the display data
  modport master (
    output adc_data, adc_valid, run, trig_level, trig_slope, decim,
    output pixel_xpos, pixel_ypos,
    input  wave_data, capture_busy, frame_swap, trig_state
  );

  // The capture buffer itself
  modport slave (
    input  adc_data, adc_valid, run, trig_level, trig_slope, decim,
    input  pixel_xpos, pixel_ypos,
    output wave_data, capture_busy, frame_swap, trig_state
  );
endinterface

// File: rtl/wave_capture_buffer.sv
// wave_capture_buffer: waits for a level/slope trigger on the ADC stream,
// stores one screen of decimated samples into the back bank of a ping-pong
// RAM, and swaps banks at frame start so the display never shows a partial
// capture. The front bank is read out by pixel column for the display.
// Optional feature: define WAVE_AUTO_TRIG_EN to force a trigger after
// AUTO_TIMEOUT valid samples spent waiting, so flat input still refreshes.
module wave_capture_buffer #(
  parameter int X_START      = 9,
  parameter int POINTS       = 1903,
  parameter int ADDR_W       = 11,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                 pixel_clk,
  input  logic                 sys_rst,
  wave_capture_buffer_if.slave cap_if
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [11:0]       X_FIRST   = 12'(X_START);
  localparam logic [11:0]       X_LAST    = 12'(X_START + POINTS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(POINTS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_disp_bank, w_disp_bank_next;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
  logic [7:0]        r_dec_cnt, w_dec_cnt_next;
  logic [7:0]        r_decim_lat, w_decim_lat_next;
  logic [7:0]        r_prev;
  logic              r_frame_swap, w_frame_swap_next;

  logic              w_we;
  logic [ADDR_W-1:0] w_we_addr;
  logic              w_rise_hit;
  logic              w_fall_hit;
  logic              w_trig_hit;
  logic              w_auto_fire;
  logic              w_trig_take;
  logic              w_frame_start;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_in_range;
  logic              r_in_range;
  logic              r_rd_bank;
  logic [7:0]        w_bank_q [2];

  // ---------------------------------------------------------------------
  // Trigger detection against the previous valid sample (unsigned compare)
  // ---------------------------------------------------------------------
  assign w_rise_hit = (r_prev < cap_if.trig_level) && (cap_if.adc_data >= cap_if.trig_level);
  assign w_fall_hit = (r_prev > cap_if.trig_level) && (cap_if.adc_data <= cap_if.trig_level);
  assign w_trig_hit = cap_if.adc_valid && (cap_if.trig_slope ? w_rise_hit : w_fall_hit);
  assign w_trig_take = w_trig_hit || w_auto_fire;

  assign w_frame_start = (cap_if.pixel_xpos == 12'd0) && (cap_if.pixel_ypos == 12'd0);

  // Previous-sample register follows every valid sample regardless of state
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_prev <= 8'd0;
    end else if (cap_if.adc_valid) begin
      r_prev <= cap_if.adc_data;
    end
  end

`ifdef WAVE_AUTO_TRIG_EN
  // ---------------------------------------------------------------------
  // Auto trigger: count valid samples while waiting; the AUTO_TIMEOUT-th
  // one is treated exactly like a real trigger hit.
  // ---------------------------------------------------------------------
  logic [15:0] r_auto_cnt, w_auto_cnt_next;

  assign w_auto_fire = (r_state == S_WAIT) && cap_if.adc_valid &&
                       (r_auto_cnt == 16'(AUTO_TIMEOUT - 1));

  // Counter is held at zero outside WAIT_TRIG, so every entry starts fresh
  always_comb begin
    w_auto_cnt_next = r_auto_cnt;
    if (r_state != S_WAIT) begin
      w_auto_cnt_next = 16'd0;
    end else if (cap_if.adc_valid) begin
      w_auto_cnt_next = r_auto_cnt + 16'd1;
    end
  end

  // Auto-trigger counter register
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_auto_cnt <= 16'd0;
    end else begin
      r_auto_cnt <= w_auto_cnt_next;
    end
  end
`else
  // Without the auto trigger only a real hit (or run=0) leaves WAIT_TRIG
  logic [31:0] w_unused_auto_timeout;
  assign w_unused_auto_timeout = 32'(AUTO_TIMEOUT);
  assign w_auto_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Capture FSM: next state, write request, bank swap
  // ---------------------------------------------------------------------
  // Next-state and write-port decisions; every output defaulted first
  always_comb begin
    w_state_next      = r_state;
    w_disp_bank_next  = r_disp_bank;
    w_wr_addr_next    = r_wr_addr;
    w_dec_cnt_next    = r_dec_cnt;
    w_decim_lat_next  = r_decim_lat;
    w_frame_swap_next = 1'b0;
    w_we              = 1'b0;
    w_we_addr         = r_wr_addr;

    unique case (r_state)
      S_IDLE: begin
        if (cap_if.run) begin
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        // run=0 wins over a simultaneous hit; frame start has no effect here
        if (!cap_if.run) begin
          w_state_next = S_IDLE;
        end else if (w_trig_take) begin
          w_state_next     = S_CAPTURE;
          w_we             = 1'b1;
          w_we_addr        = '0;
          w_wr_addr_next   = ADDR_W'(1);
          w_dec_cnt_next   = 8'd0;
          w_decim_lat_next = cap_if.decim;
        end
      end

      S_CAPTURE: begin
        // Keep one of every (decim+1) valid samples after the trigger sample
        if (cap_if.adc_valid) begin
          if (r_dec_cnt == r_decim_lat) begin
            w_we           = 1'b1;
            w_wr_addr_next = r_wr_addr + ADDR_W'(1);
            w_dec_cnt_next = 8'd0;
            if (r_wr_addr == LAST_ADDR) begin
              w_state_next = S_DONE;
            end
          end else begin
            w_dec_cnt_next = r_dec_cnt + 8'd1;
          end
        end
      end

      S_DONE: begin
        // Hold the finished capture until the top-left pixel, then flip banks
        if (w_frame_start) begin
          w_disp_bank_next  = ~r_disp_bank;
          w_frame_swap_next = 1'b1;
          w_state_next      = cap_if.run ? S_WAIT : S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM and capture bookkeeping registers
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_disp_bank  <= 1'b0;
      r_wr_addr    <= '0;
      r_dec_cnt    <= 8'd0;
      r_decim_lat  <= 8'd0;
      r_frame_swap <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_disp_bank  <= w_disp_bank_next;
      r_wr_addr    <= w_wr_addr_next;
      r_dec_cnt    <= w_dec_cnt_next;
      r_decim_lat  <= w_decim_lat_next;
      r_frame_swap <= w_frame_swap_next;
    end
  end

  // ---------------------------------------------------------------------
  // Ping-pong sample RAM: writes go to the back bank, scan-out reads the
  // front bank. Each bank has one write and one registered read port.
  // ---------------------------------------------------------------------
  assign w_rd_addr  = ADDR_W'(cap_if.pixel_xpos - X_FIRST);
  assign w_in_range = (cap_if.pixel_xpos >= X_FIRST) && (cap_if.pixel_xpos <= X_LAST);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      logic       w_bank_we;

      assign w_bank_we = w_we && (r_disp_bank != 1'(gi));

      // Back-bank write of the kept sample; synchronous read for scan-out
      always_ff @(posedge pixel_clk) begin
        if (w_bank_we) begin
          r_mem[w_we_addr] <= cap_if.adc_data;
        end
        r_q <= r_mem[w_rd_addr];
      end

      assign w_bank_q[gi] = r_q;
    end
  endgenerate

  // Read-side qualifiers registered alongside the RAM data
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_in_range <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_in_range <= w_in_range;
      r_rd_bank  <= r_disp_bank;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cap_if.wave_data    = r_in_range ? w_bank_q[r_rd_bank] : 8'd0;
  assign cap_if.trig_state   = r_state;
  assign cap_if.capture_busy = (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign cap_if.frame_swap   = r_frame_swap;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// tb_wave_capture_buffer: randomized stimulus against a behavioural model of
// the capture buffer (queue of kept samples, displayed-frame array).
`timescale 1ns/1ps
module tb_wave_capture_buffer;

  localparam int X_START = 9;
  localparam int POINTS  = 1903;
  localparam int ADDR_W  = 11;
  localparam int X_LAST  = X_START + POINTS - 1;
`ifdef WAVE_AUTO_TRIG_EN
  localparam int TB_AUTO = 1000;
`else
  localparam int TB_AUTO = 65535;
`endif
  localparam int BUDGET = 30000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_capture_buffer_if bus ();

  wave_capture_buffer #(
    .X_START     (X_START),
    .POINTS      (POINTS),
    .ADDR_W      (ADDR_W),
    .AUTO_TIMEOUT(TB_AUTO)
  ) dut (
    .pixel_clk(clk),
    .sys_rst  (rst),
    .cap_if   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int   m_mode;            // 0 idle, 1 waiting, 2 capturing, 3 done
  int   m_prev;
  int   m_since;           // valid samples seen since the trigger sample
  int   m_decim;
  int   m_auto;
  int   m_cap[$];          // samples kept for the capture in progress
  int   m_front[POINTS];   // samples currently on screen
  bit   m_front_known;
  bit   m_swap;
  int   m_exp_wave;
  bit   m_exp_known;
  int   ramp;

  logic [7:0] obs [2048];
  int         expw[2048];
  bit         expk[2048];

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_since = 0; m_decim = 0; m_auto = 0;
    m_cap.delete(); m_front_known = 1'b0; m_swap = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, land on the next falling edge
  task automatic tick(input bit v, input int d, input int x, input int y);
    bit fs;
    bit hit;
    int lvl;
    bus.adc_valid  = v;
    bus.adc_data   = 8'(d);
    bus.pixel_xpos = 12'(x);
    bus.pixel_ypos = 12'(y);
    fs  = (x == 0) && (y == 0);
    lvl = int'(bus.trig_level);
    if (x >= X_START && x <= X_LAST) begin
      m_exp_known = m_front_known;
      m_exp_wave  = m_front[x - X_START];
    end else begin
      m_exp_known = 1'b1;
      m_exp_wave  = 0;
    end
    hit = v && (bus.trig_slope ? (m_prev < lvl && d >= lvl) : (m_prev > lvl && d <= lvl));
`ifdef WAVE_AUTO_TRIG_EN
    if (m_mode == 1 && v && m_auto + 1 >= TB_AUTO) hit = 1'b1;
`endif
    m_swap = 1'b0;
    case (m_mode)
      0: if (bus.run) begin m_mode = 1; m_auto = 0; end
      1: begin
        if (!bus.run) m_mode = 0;
        else if (hit) begin
          m_mode = 2; m_cap.delete(); m_cap.push_back(d);
          m_since = 0; m_decim = int'(bus.decim);
        end else if (v) m_auto++;
      end
      2: if (v) begin
        m_since++;
        if (m_since % (m_decim + 1) == 0) begin
          m_cap.push_back(d);
          if (m_cap.size() == POINTS) m_mode = 3;
        end
      end
      default: if (fs) begin
        foreach (m_front[i]) m_front[i] = m_cap[i];
        m_front_known = 1'b1;
        m_swap = 1'b1;
        m_mode = bus.run ? 1 : 0;
        m_auto = 0;
      end
    endcase
    if (v) m_prev = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random valid strobe, random column; cval<0 means ramp data else constant
  task automatic feed(input int cval, output bit v);
    int x;
    int y;
    v = ($urandom_range(0, 3) != 0);
    x = $urandom_range(1, 2100);
    y = $urandom_range(1, 500);
    if ($urandom_range(0, 199) == 0) begin x = 0; y = 0; end
    if (!v) tick(1'b0, $urandom_range(0, 255), x, y);
    else if (cval >= 0) tick(1'b1, cval, x, y);
    else begin tick(1'b1, ramp, x, y); ramp = (ramp + 1) % 256; end
  endtask

  // Walk every column once and record what came back with the model's view
  task automatic sweep();
    for (int x = 0; x < 2048; x++) begin
      tick(1'b0, 0, x, 1);
      obs[x]  = bus.wave_data;
      expw[x] = m_exp_wave;
      expk[x] = m_exp_known;
    end
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.trig_level = 8'd128; bus.trig_slope = 1'b1; bus.decim = 8'd0;
    bus.adc_valid = 1'b0; bus.adc_data = 8'd0; bus.pixel_xpos = 12'd20; bus.pixel_ypos = 12'd1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.trig_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", bus.trig_state); end
    n_vec++; if (bus.wave_data !== 8'd0) begin n_err++; $display("FAIL reset_wave: got %0d expected 0", bus.wave_data); end
    n_vec++; if (bus.capture_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.capture_busy); end
    n_vec++; if (bus.frame_swap !== 1'b0) begin n_err++; $display("FAIL reset_swap: got %b expected 0", bus.frame_swap); end
    rst = 1'b0;
    model_reset();
    tick(1'b0, 0, 20, 1);
    n_vec++; if (bus.trig_state !== 2'd0) begin n_err++; $display("FAIL idle_hold: got %0d expected 0", bus.trig_state); end
    $display("test_reset done");
  endtask

  task automatic test_rising_ramp();
    bit v;
    bus.trig_level = 8'd128; bus.trig_slope = 1'b1; bus.decim = 8'd0; bus.run = 1'b1;
    ramp = 0;
    for (int c = 0; c < BUDGET && m_mode != 3; c++) begin
      feed(-1, v);
      n_vec++;
      if (bus.trig_state !== 2'(m_mode) || bus.capture_busy !== (m_mode == 1 || m_mode == 2) || bus.frame_swap !== m_swap) begin
        n_err++; $display("FAIL rise_cap: state=%0d busy=%b swap=%b expected state=%0d swap=%b", bus.trig_state, bus.capture_busy, bus.frame_swap, m_mode, m_swap);
      end
    end
    n_vec++; if (bus.trig_state !== 2'd3) begin n_err++; $display("FAIL rise_done: got state %0d expected 3", bus.trig_state); end
    // Capture finished mid-frame: nothing may swap before the top-left pixel
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 0, $urandom_range(1, 2100), 7);
      n_vec++;
      if (bus.trig_state !== 2'd3 || bus.frame_swap !== 1'b0 || bus.wave_data !== 8'(m_exp_wave)) begin
        if (m_exp_known || bus.trig_state !== 2'd3 || bus.frame_swap !== 1'b0) begin
          n_err++; $display("FAIL rise_hold: state=%0d swap=%b wave=%0d expected state=3 swap=0 wave=%0d", bus.trig_state, bus.frame_swap, bus.wave_data, m_exp_wave);
        end
      end
    end
    tick(1'b0, 0, 0, 0);
    n_vec++; if (bus.frame_swap !== 1'b1) begin n_err++; $display("FAIL rise_swap: got %b expected 1", bus.frame_swap); end
    n_vec++; if (bus.trig_state !== 2'd1) begin n_err++; $display("FAIL rise_rearm: got %0d expected 1", bus.trig_state); end
    bus.run = 1'b0;
    tick(1'b0, 0, 30, 3);
    n_vec++; if (bus.frame_swap !== 1'b0) begin n_err++; $display("FAIL rise_swap_width: got %b expected 0", bus.frame_swap); end
    sweep();
    for (int x = 0; x < 2048; x++) begin
      if (expk[x]) begin
        n_vec++; if (obs[x] !== 8'(expw[x])) begin n_err++; $display("FAIL rise_col%0d: got %0d expected %0d", x, obs[x], expw[x]); end
      end
    end
    n_vec++; if (obs[9] !== 8'd128) begin n_err++; $display("FAIL rise_col9_const: got %0d expected 128", obs[9]); end
    n_vec++; if (obs[10] !== 8'd129) begin n_err++; $display("FAIL rise_col10_const: got %0d expected 129", obs[10]); end
    n_vec++; if (obs[1911] !== 8'd238) begin n_err++; $display("FAIL rise_col1911_const: got %0d expected 238", obs[1911]); end
    $display("test_rising_ramp done");
  endtask

  task automatic test_falling_wrap();
    bit v;
    tick(1'b1, 0, 40, 2);   // seed previous sample while idle
    bus.trig_level = 8'd64; bus.trig_slope = 1'b0; bus.decim = 8'd0; bus.run = 1'b1;
    ramp = 1;
    for (int c = 0; c < BUDGET && m_mode != 3; c++) begin
      feed(-1, v);
      n_vec++;
      if (bus.trig_state !== 2'(m_mode) || bus.frame_swap !== m_swap || (m_exp_known && bus.wave_data !== 8'(m_exp_wave))) begin
        n_err++; $display("FAIL fall_cap: state=%0d swap=%b wave=%0d expected state=%0d swap=%b wave=%0d", bus.trig_state, bus.frame_swap, bus.wave_data, m_mode, m_swap, m_exp_wave);
      end
    end
    bus.run = 1'b0;
    tick(1'b0, 0, 0, 0);
    n_vec++; if (bus.frame_swap !== 1'b1) begin n_err++; $display("FAIL fall_swap: got %b expected 1", bus.frame_swap); end
    n_vec++; if (bus.trig_state !== 2'd0) begin n_err++; $display("FAIL fall_idle_after_swap: got %0d expected 0", bus.trig_state); end
    sweep();
    for (int x = 0; x < 2048; x++) begin
      if (expk[x]) begin
        n_vec++; if (obs[x] !== 8'(expw[x])) begin n_err++; $display("FAIL fall_col%0d: got %0d expected %0d", x, obs[x], expw[x]); end
      end
    end
    n_vec++; if (obs[9] !== 8'd0) begin n_err++; $display("FAIL fall_col9_const: got %0d expected 0", obs[9]); end
    n_vec++; if (obs[10] !== 8'd1) begin n_err++; $display("FAIL fall_col10_const: got %0d expected 1", obs[10]); end
    $display("test_falling_wrap done");
  endtask

  task automatic test_decim();
    bit v;
    int n_cap;
    int bad;
    logic [1:0] s_before;
    bus.trig_level = 8'd128; bus.trig_slope = 1'b1; bus.decim = 8'd3; bus.run = 1'b1;
    ramp = 0; n_cap = 0;
    for (int c = 0; c < BUDGET && m_mode != 3; c++) begin
      s_before = bus.trig_state;
      feed(-1, v);
      if (v && (s_before == 2'd2 || (s_before == 2'd1 && bus.trig_state == 2'd2))) n_cap++;
      if (bus.trig_state == 2'd2) bus.decim = 8'd7;   // must not disturb the latched value
      n_vec++;
      if (bus.trig_state !== 2'(m_mode) || (m_exp_known && bus.wave_data !== 8'(m_exp_wave))) begin
        n_err++; $display("FAIL decim_cap: state=%0d wave=%0d expected state=%0d wave=%0d", bus.trig_state, bus.wave_data, m_mode, m_exp_wave);
      end
    end
    n_vec++; if (n_cap != 4 * (POINTS - 1) + 1) begin n_err++; $display("FAIL decim_sample_count: got %0d expected %0d", n_cap, 4 * (POINTS - 1) + 1); end
    bus.run = 1'b0;
    tick(1'b0, 0, 0, 0);
    n_vec++; if (bus.frame_swap !== 1'b1 || bus.trig_state !== 2'd0) begin n_err++; $display("FAIL decim_swap: swap=%b state=%0d expected swap=1 state=0", bus.frame_swap, bus.trig_state); end
    sweep();
    for (int x = 0; x < 2048; x++) begin
      if (expk[x]) begin
        n_vec++; if (obs[x] !== 8'(expw[x])) begin n_err++; $display("FAIL decim_col%0d: got %0d expected %0d", x, obs[x], expw[x]); end
      end
    end
    bad = 0;
    for (int x = X_START; x < X_LAST; x++) if (8'(obs[x + 1] - obs[x]) !== 8'd4) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL decim_step: %0d column pairs differ by other than 4, expected 0", bad); end
    n_vec++; if (obs[9] !== 8'd128) begin n_err++; $display("FAIL decim_col9_const: got %0d expected 128", obs[9]); end
    $display("test_decim done");
  endtask

  task automatic test_reset_mid_capture();
    bit v;
    int n_wr;
    logic [1:0] s_before;
    bus.trig_level = 8'd128; bus.trig_slope = 1'b1; bus.decim = 8'd0; bus.run = 1'b1;
    ramp = 0; n_wr = 0;
    for (int c = 0; c < BUDGET && n_wr < 100; c++) begin
      s_before = bus.trig_state;
      feed(-1, v);
      if (v && s_before == 2'd2) n_wr++;
    end
    n_vec++; if (bus.trig_state !== 2'd2) begin n_err++; $display("FAIL rstmid_capturing: got %0d expected 2", bus.trig_state); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.trig_state !== 2'd0 || bus.wave_data !== 8'd0 || bus.capture_busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_immediate: state=%0d wave=%0d busy=%b expected 0 0 0", bus.trig_state, bus.wave_data, bus.capture_busy);
    end
    n_vec++; if (dut.r_disp_bank !== 1'b0) begin n_err++; $display("FAIL rstmid_bank: got %b expected 0", dut.r_disp_bank); end
    for (int c = 0; c < 4; c++) begin
      bus.adc_valid = 1'b1; bus.adc_data = 8'(200 + c); bus.pixel_xpos = 12'(50 + c); bus.pixel_ypos = 12'd0;
      @(posedge clk); @(negedge clk);
      n_vec++; if (bus.trig_state !== 2'd0 || bus.wave_data !== 8'd0 || bus.frame_swap !== 1'b0) begin
        n_err++; $display("FAIL rstmid_held: state=%0d wave=%0d swap=%b expected 0 0 0", bus.trig_state, bus.wave_data, bus.frame_swap);
      end
    end
    bus.adc_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    $display("test_reset_mid_capture done");
  endtask

  task automatic test_auto_trig();
    bit v;
    int bad;
    bus.trig_level = 8'd128; bus.trig_slope = 1'b1; bus.decim = 8'd0; bus.run = 1'b1;
`ifdef WAVE_AUTO_TRIG_EN
    for (int c = 0; c < BUDGET && m_mode != 3; c++) begin
      feed(50, v);
      n_vec++;
      if (bus.trig_state !== 2'(m_mode)) begin n_err++; $display("FAIL auto_cap: state=%0d expected %0d", bus.trig_state, m_mode); end
    end
    bus.run = 1'b0;
    tick(1'b0, 0, 0, 0);
    n_vec++; if (bus.frame_swap !== 1'b1) begin n_err++; $display("FAIL auto_swap: got %b expected 1", bus.frame_swap); end
    sweep();
    bad = 0;
    for (int x = X_START; x <= X_LAST; x++) if (obs[x] !== 8'd50) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL auto_flat: %0d columns not 50, expected 0", bad); end
`else
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      feed(50, v);
      n_vec++;
      if (bus.trig_state !== 2'(m_mode) || bus.trig_state !== 2'd1) begin n_err++; $display("FAIL auto_off_wait: state=%0d expected 1", bus.trig_state); end
    end
    bus.run = 1'b0;
    tick(1'b0, 0, 33, 3);
    n_vec++; if (bus.trig_state !== 2'd0) begin n_err++; $display("FAIL auto_off_stop: got %0d expected 0", bus.trig_state); end
`endif
    $display("test_auto_trig done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    ramp = 0;
    test_reset();
    test_rising_ramp();
    test_falling_wrap();
    test_decim();
    test_reset_mid_capture();
    test_auto_trig();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
